seq_divider: RTL and testbench
==============================

# seq_divider

Sequential unsigned restoring divider that inverts the team's sequential multiplier. It takes a 2N-bit dividend, such as a multiplier product, and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder. It resolves one quotient bit per clock and uses the same `load`/`valid` handshake as the multiplier, so the two blocks can be chained and cross-checked in multiply-then-divide benches.

## Interface
- `N`, default 4: divisor width; dividend and quotient are 2N bits.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: start request, sampled on the rising edge of `clk`.
- `a`, input, 2N: dividend, captured on the accepted `load` edge.
- `b`, input, N: divisor, captured on the accepted `load` edge.
- `q`, output, 2N: quotient, registered.
- `r`, output, N: remainder, registered.
- `valid`, output, 1: `q`, `r` and `div_by_zero` hold the result of the last accepted operation.
- `busy`, output, 1: high while an iteration is in progress.
- `div_by_zero`, output, 1: the last accepted operation had `b == 0`.

## Operation
- States:
  - IDLE: after reset, no result.
  - RUN: iterating.
  - DONE: result held.
- Load acceptance:
  - `load` is accepted only in IDLE or DONE.
  - `load` is ignored in RUN, with no restart and no effect on the captured operands.
- Accepted load with `b != 0`:
  - Capture the dividend into shift register `dq` (2N bits) and the divisor into `d` (N bits).
  - Clear the partial remainder `pr` (N+1 bits).
  - Set the iteration counter to 2N.
  - `valid` <= 0, `busy` <= 1, next state RUN.
- RUN, each edge:
  - `t = {pr[N-1:0], dq[2N-1]}`.
  - If `t >= {1'b0, d}`: `pr <= t - d` and shift 1 into the `dq` LSB.
  - Else: `pr <= t` and shift 0 into the `dq` LSB.
  - `dq` shifts left by one; the counter decrements.
- Last RUN edge (counter == 1):
  - `q <= ` the final shifted `dq`; `r <=` the final `pr[N-1:0]`.
  - `valid` <= 1, `busy` <= 0, `div_by_zero` <= 0, next state DONE.
- Accepted load with `b == 0`:
  - Go straight to DONE.
  - `q <= {2N{1'b1}}`, `r <= 0`, `div_by_zero <= 1`, `valid <= 1`, `busy` stays 0.
- Output hold:
  - `q` and `r` update only at completion.
  - During RUN they keep the previous result, with `valid` low.
- Arithmetic:
  - All operations are unsigned.
  - `pr` is N+1 bits so the compare never overflows; the remainder is always less than `b`.
  - `q*b + r == a` for every nonzero `b`.
- Reset (asynchronous, any state, including mid-RUN):
  - State IDLE.
  - `q = 0`, `r = 0`, `valid = 0`, `busy = 0`, `div_by_zero = 0`.
  - Counter, `pr`, `dq` and `d` cleared.
  - The operation in progress is discarded.

## Timing
- Call the accepting edge E0.
- Normal latency:
  - `busy` is high from E0 through E0+2N-1.
  - `valid`, `q` and `r` are updated at edge E0+2N, which is 8 edges for N=4.
- Divide-by-zero latency: `valid` and `div_by_zero` are high after E0 itself.
- Throughput: one operation per 2N+1 edges with back-to-back loads.
  - `load` is held at E0+2N.
  - The result is present for zero cycles visible only if that edge is DONE→RUN.
  - Because the completion edge moves to DONE, a `load` held at E0+2N is still in RUN and is ignored.
  - The next load is accepted at E0+2N+1 or later.
- Restart from DONE: `valid` falls at the accepting edge.
- Holding `load` high continuously in DONE restarts on every DONE edge.
- `rst` takes effect immediately, independent of `clk`.
- An edge with `rst` high ignores `load`.

## Test plan
- Reset, then `a=8`, `b=4`, `load` for 1 cycle:
  - `valid` rises exactly 8 edges after E0.
  - `q=2`, `r=0`, `div_by_zero=0`; `busy` is high for 8 cycles.
- `a=45`, `b=15`, then `a=225`, `b=15`, loaded back-to-back from DONE:
  - Results `q=3`, `r=0`, then `q=15`, `r=0`.
  - `valid` falls at each accepting edge.
- `a=100`, `b=7` → `q=14`, `r=2`.
  - `a=255`, `b=1` → `q=255`, `r=0`.
  - `a=3`, `b=15` → `q=0`, `r=3`.
  - Randomized sweep of all (`a`, `b≠0`) pairs for N=4 checks `q*b+r==a` and `r<b`.
- `a=77`, `b=0`:
  - After E0, `valid=1`, `div_by_zero=1`, `q=255`, `r=0`, `busy` never high.
  - A following `a=77`, `b=5` gives `q=15`, `r=2` and clears `div_by_zero`.
- Start `a=200`, `b=9`, then pulse `load` with `a=1`, `b=1` at E0+3:
  - The second load is ignored; the result is `q=22`, `r=2` at E0+8.
- Start `a=200`, `b=9` and assert `rst` mid-cycle at E0+4, off-edge:
  - All outputs go to 0 immediately.
  - After release, no `valid` appears until a new load; a new `a=50`, `b=6` gives `q=8`, `r=2`.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Sequential unsigned restoring divider, 2N/N -> 2N quotient, N rem,
//            one quotient bit per clock, load/valid handshake.
// Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           valid,
  output logic           busy,
  output logic           div_by_zero
);

  localparam int                 c_cnt_w = $clog2(2*N) + 1;
  localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(2*N);
  localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [N-1:0]         r_pr;
  logic [2*N-1:0]       r_dq;
  logic [N-1:0]         r_d;
  logic [N:0]           w_t;
  logic [N:0]           w_diff;
  logic                 w_ge;
  logic [N-1:0]         w_pr_nxt;
  logic [2*N-1:0]       w_dq_nxt;

  // Trial subtraction is N+1 bits wide. Since pr < d always holds, t < 2d, so
  // the borrow bit of t - d is exactly the (t >= d) decision and the stored
  // partial remainder never needs its top bit.
  assign w_t      = {r_pr, r_dq[2*N-1]};
  assign w_diff   = w_t - {1'b0, r_d};
  assign w_ge     = ~w_diff[N];
  assign w_pr_nxt = w_ge ? w_diff[N-1:0] : w_t[N-1:0];
  assign w_dq_nxt = {r_dq[2*N-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = (b == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_one) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_pr        <= '0;
      r_dq        <= '0;
      r_d         <= '0;
      q           <= '0;
      r           <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      if (b == '0) begin
        q           <= '1;
        r           <= '0;
        div_by_zero <= 1'b1;
        valid       <= 1'b1;
        busy        <= 1'b0;
      end else begin
        r_dq  <= a;
        r_d   <= b;
        r_pr  <= '0;
        r_cnt <= c_iters;
        valid <= 1'b0;
        busy  <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_pr  <= w_pr_nxt;
      r_dq  <= w_dq_nxt;
      r_cnt <= r_cnt - c_one;
      if (r_cnt == c_one) begin
        q           <= w_dq_nxt;
        r           <= w_pr_nxt;
        valid       <= 1'b1;
        busy        <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Purpose  : Directed plus randomized bench for seq_divider (N=4) against an
//            arithmetic reference (/ and %).
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] a;
  logic [3:0] b;
  logic [7:0] q;
  logic [3:0] r;
  logic       valid;
  logic       busy;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .valid       (valid),
    .busy        (busy),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands for one edge; returns 1ns after the accepting edge.
  task automatic start(input logic [7:0] ta, input logic [3:0] tb_);
    @(negedge clk);
    a    = ta;
    b    = tb_;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = busy ? 1 : 0;
    while (!valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
    end
    chk("done_timeout", valid, 1);
  endtask

  task automatic check_op(input logic [7:0] ta, input logic [3:0] tb_);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    if (tb_ == 0) begin
      eq = 8'd255; er = 4'd0; ez = 1'b1;
    end else begin
      eq = ta / tb_; er = 4'(ta % tb_); ez = 1'b0;
    end
    chk("q", q, eq);
    chk("r", r, er);
    chk("div_by_zero", div_by_zero, ez);
    chk("valid", valid, 1);
    if (tb_ != 0) begin
      chk("q*b+r", 32'(q) * 32'(tb_) + 32'(r), 32'(ta));
      chk("r<b", 32'(r < tb_), 1);
    end
  endtask

  task automatic full_op(input logic [7:0] ta, input logic [3:0] tb_);
    int e, bc;
    start(ta, tb_);
    if (tb_ != 0) wait_done(e, bc);
    check_op(ta, tb_);
  endtask

  initial begin
    int edges, bcnt, vseen;
    rst  = 1'b1;
    load = 1'b0;
    a    = '0;
    b    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic latency and busy window
    start(8'd8, 4'd4);
    chk("e0_busy", busy, 1);
    chk("e0_valid", valid, 0);
    wait_done(edges, bcnt);
    chk("latency_8_4", edges, 8);
    chk("busy_cycles", bcnt, 8);
    check_op(8'd8, 4'd4);

    // Back-to-back from DONE
    start(8'd45, 4'd15);
    chk("valid_fall_1", valid, 0);
    wait_done(edges, bcnt);
    check_op(8'd45, 4'd15);
    start(8'd225, 4'd15);
    chk("valid_fall_2", valid, 0);
    wait_done(edges, bcnt);
    chk("latency_225_15", edges, 8);
    check_op(8'd225, 4'd15);

    full_op(8'd100, 4'd7);
    full_op(8'd255, 4'd1);
    full_op(8'd3, 4'd15);

    // Divide by zero completes at the accepting edge
    start(8'd77, 4'd0);
    check_op(8'd77, 4'd0);
    chk("dbz_busy_e0", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("dbz_busy_hold", busy, 0);
      chk("dbz_valid_hold", valid, 1);
    end
    full_op(8'd77, 4'd5);

    // Load during RUN is ignored
    start(8'd200, 4'd9);
    repeat (3) @(negedge clk);
    a    = 8'd1;
    b    = 4'd1;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("ignored_load_busy", busy, 1);
    wait_done(edges, bcnt);
    chk("ignored_load_latency", edges, 5);
    check_op(8'd200, 4'd9);

    // Asynchronous reset mid-run
    start(8'd200, 4'd9);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q", q, 0);
    chk("arst_r", r, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst   = 1'b0;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) vseen++;
    end
    chk("post_rst_idle", vseen, 0);
    full_op(8'd50, 4'd6);

    // Randomized operations, zero divisor included
    for (int i = 0; i < 100; i++) begin
      full_op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    // Every (a, b != 0) pair, visited from a random starting offset
    begin
      int off;
      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
        for (int j = 1; j < 16; j++) begin
          full_op(8'((i + off) % 256), 4'(j));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
